// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : UART state encoding and parity codes shared by the TX and RX blocks.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Synchronous FIFO with full/empty/one-entry flags and show-ahead read.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             i_Rst_L,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_last
);
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (c_AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_last  = (r_count == (c_AW+1)'(1));

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Configurable UART transmitter (width, divisor, parity, stop bits).
//           Define UART_TX_FIFO_EN to add an input FIFO with gapless frames.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int CNT_W        = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_TX_Ready,
  output logic                 TX,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);
  localparam int c_WORD_W = DATA_BITS + CNT_W + 3;
  localparam int c_IDX_W  = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2) begin : g_bad_param
    $error("uart_tx_cfg: DATA_BITS must be 5..9 and FIFO_DEPTH >= 2");
  end

  tx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic                 r_tx, w_tx_nxt;

  logic [CNT_W-1:0]     w_eff_div;
  logic [c_WORD_W-1:0]  w_in_word;
  logic [c_WORD_W-1:0]  w_cur_word;
  logic [DATA_BITS-1:0] w_cur_data;
  logic [CNT_W-1:0]     w_cur_div;
  logic [1:0]           w_cur_par;
  logic                 w_cur_two;
  logic                 w_accept, w_bit_end, w_last_stop, w_frame_end;
  logic                 w_go_idle, w_go_next, w_par_bit, w_data_bit;
  logic [c_IDX_W-1:0]   w_idx_inc;

  always_comb begin
    if (i_Clks_Per_Bit == '0)               w_eff_div = CNT_W'(CLKS_PER_BIT);
    else if (i_Clks_Per_Bit == CNT_W'(1))   w_eff_div = CNT_W'(2);
    else                                    w_eff_div = i_Clks_Per_Bit;
  end

  assign w_in_word = {i_TX_Byte, w_eff_div, i_Parity_Mode, i_Two_Stop};
  assign w_accept  = i_TX_DV & o_TX_Ready;
  assign {w_cur_data, w_cur_div, w_cur_par, w_cur_two} = w_cur_word;

`ifdef UART_TX_FIFO_EN
  // The FIFO head is the frame in flight; it is popped only when that frame ends.
  logic w_fifo_full, w_fifo_empty, w_fifo_last;

  uart_tx_fifo #(
    .WIDTH (c_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .i_Rst_L (i_Rst_L),
    .i_push  (w_accept),
    .i_wdata (w_in_word),
    .i_pop   (w_frame_end),
    .o_rdata (w_cur_word),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_last  (w_fifo_last)
  );

  assign o_TX_Ready = ~w_fifo_full;
  assign w_go_idle  = ~w_fifo_empty | w_accept;
  assign w_go_next  = ~w_fifo_last | w_accept;
`else
  logic [c_WORD_W-1:0] r_word;

  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L)      r_word <= '0;
    else if (w_accept) r_word <= w_in_word;
  end

  assign w_cur_word = r_word;
  assign o_TX_Ready = (r_state == IDLE);
  assign w_go_idle  = w_accept;
  assign w_go_next  = 1'b0;
`endif

  always_comb begin
    case (w_cur_par)
      PAR_EVEN: w_par_bit = ^w_cur_data;
      PAR_ODD:  w_par_bit = ~^w_cur_data;
      PAR_MARK: w_par_bit = 1'b1;
      default:  w_par_bit = 1'b1;
    endcase
  end

  assign w_bit_end   = (r_cnt == w_cur_div - CNT_W'(1));
  assign w_last_stop = (r_idx == c_IDX_W'(w_cur_two));
  assign w_frame_end = (r_state == STOP) & w_bit_end & w_last_stop;
  assign w_idx_inc   = r_idx + c_IDX_W'(1);
  assign w_data_bit  = |(w_cur_data & (DATA_BITS'(1) << w_idx_inc));

  // TX is computed one cycle ahead so the pin itself is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (w_go_idle) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
        w_tx_nxt    = w_cur_data[0];
      end
      DATA: if (w_bit_end) begin
        if (r_idx == c_IDX_W'(DATA_BITS - 1)) begin
          w_idx_nxt = '0;
          if (w_cur_par != PAR_NONE) begin
            w_state_nxt = PARITY;
            w_tx_nxt    = w_par_bit;
          end else begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_idx_nxt = w_idx_inc;
          w_tx_nxt  = w_data_bit;
        end
      end
      PARITY: if (w_bit_end) begin
        w_state_nxt = STOP;
        w_idx_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
      STOP: if (w_bit_end) begin
        if (w_last_stop) begin
          w_idx_nxt = '0;
          if (w_go_next) begin
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_idx_nxt = w_idx_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign TX          = r_tx;
  assign o_TX_Active = (r_state != IDLE);
  assign o_TX_Done   = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Self-checking bench for uart_tx_cfg with a per-bit scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;
  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        i_Rst_L;
  logic        i_TX_DV;
  logic [7:0]  i_TX_Byte;
  logic [15:0] i_Clks_Per_Bit;
  logic [1:0]  i_Parity_Mode;
  logic        i_Two_Stop;
  logic        o_TX_Ready, TX, o_TX_Active, o_TX_Done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic lvl;
    logic last;
    int   len;
  } seg_t;
  seg_t sb[$];

  always #5 CLK = ~CLK;

  uart_tx_cfg #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK            (CLK),
    .i_Rst_L        (i_Rst_L),
    .i_TX_DV        (i_TX_DV),
    .i_TX_Byte      (i_TX_Byte),
    .i_Clks_Per_Bit (i_Clks_Per_Bit),
    .i_Parity_Mode  (i_Parity_Mode),
    .i_Two_Stop     (i_Two_Stop),
    .o_TX_Ready     (o_TX_Ready),
    .TX             (TX),
    .o_TX_Active    (o_TX_Active),
    .o_TX_Done      (o_TX_Done)
  );

  function automatic int eff_div(input logic [15:0] c);
    if (c == 16'd0) return CPB;
    if (c == 16'd1) return 2;
    return int'(c);
  endfunction

  // Expected line waveform of one frame, as (level, length) segments.
  task automatic push_frame(input logic [7:0] d, input int div, input logic [1:0] pm, input logic two);
    seg_t s;
    s.last = 1'b0;
    s.len  = div;
    s.lvl  = 1'b0;
    sb.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.lvl = d[i];
      sb.push_back(s);
    end
    if (pm != 2'b00) begin
      s.lvl = (pm == 2'b01) ? ^d : (pm == 2'b10) ? ~^d : 1'b1;
      sb.push_back(s);
    end
    s.lvl  = 1'b1;
    s.len  = two ? 2 * div : div;
    s.last = 1'b1;
    sb.push_back(s);
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] cpb, input logic [1:0] pm,
                      input logic two, input bit hold, input bit do_push);
    int w = 0;
    @(negedge CLK);
    while (o_TX_Ready !== 1'b1 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    n_checks++;
    if (o_TX_Ready !== 1'b1) $display("FAIL send_ready: got %b expected 1", o_TX_Ready);
    else n_pass++;
    i_TX_Byte      = d;
    i_Clks_Per_Bit = cpb;
    i_Parity_Mode  = pm;
    i_Two_Stop     = two;
    i_TX_DV        = 1'b1;
    if (do_push) push_frame(d, eff_div(cpb), pm, two);
    @(posedge CLK);
    #1;
    if (!hold) i_TX_DV = 1'b0;
  endtask

  task automatic drain(input string name, input bit busy_chk);
    seg_t s;
    int   cyc = 0;
    logic exp_done;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      for (int c = 0; c < s.len; c++) begin
        @(negedge CLK);
        cyc++;
        exp_done = s.last && (c == s.len - 1);
        n_checks++;
        if (TX !== s.lvl) $display("FAIL %s tx cyc %0d: got %b expected %b", name, cyc, TX, s.lvl);
        else n_pass++;
        n_checks++;
        if (o_TX_Done !== exp_done) $display("FAIL %s done cyc %0d: got %b expected %b", name, cyc, o_TX_Done, exp_done);
        else n_pass++;
        n_checks++;
        if (o_TX_Active !== 1'b1) $display("FAIL %s active cyc %0d: got %b expected 1", name, cyc, o_TX_Active);
        else n_pass++;
        if (busy_chk) begin
          n_checks++;
          if (o_TX_Ready !== 1'b0) $display("FAIL %s ready_busy cyc %0d: got %b expected 0", name, cyc, o_TX_Ready);
          else n_pass++;
        end
      end
      if (s.last) cyc = 0;
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge CLK);
    n_checks++;
    if (TX !== 1'b1) $display("FAIL %s tx: got %b expected 1", name, TX);
    else n_pass++;
    n_checks++;
    if (o_TX_Active !== 1'b0) $display("FAIL %s active: got %b expected 0", name, o_TX_Active);
    else n_pass++;
    n_checks++;
    if (o_TX_Done !== 1'b0) $display("FAIL %s done: got %b expected 0", name, o_TX_Done);
    else n_pass++;
    n_checks++;
    if (o_TX_Ready !== 1'b1) $display("FAIL %s ready: got %b expected 1", name, o_TX_Ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    i_TX_DV = 1'b0;
    i_TX_Byte = 8'h00;
    i_Clks_Per_Bit = 16'd0;
    i_Parity_Mode = 2'b00;
    i_Two_Stop = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (TX !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0 || o_TX_Ready !== 1'b1)
      $display("FAIL reset_state: got tx=%b act=%b done=%b rdy=%b expected 1 0 0 1", TX, o_TX_Active, o_TX_Done, o_TX_Ready);
    else n_pass++;
    i_Rst_L = 1'b1;
    idle_check("reset_release");
  endtask

  task automatic test_8n1();
    send(8'hA5, 16'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    drain("8n1_a5", 1'b0);
    idle_check("8n1_after");
  endtask

  task automatic test_parity();
    for (int pm = 1; pm < 4; pm++) begin
      send(8'h07, 16'd0, 2'(pm), 1'b0, 1'b0, 1'b1);
      drain("parity", 1'b0);
      idle_check("parity_after");
    end
    send(8'h07, 16'd0, 2'b11, 1'b1, 1'b0, 1'b1);
    drain("mark_2stop", 1'b0);
    idle_check("mark_2stop_after");
  endtask

  task automatic test_divisor();
    send(8'h5A, 16'd10, 2'b00, 1'b0, 1'b0, 1'b1);
    i_Clks_Per_Bit = 16'd3;
    i_TX_Byte      = 8'hFF;
    i_Parity_Mode  = 2'b01;
    i_Two_Stop     = 1'b1;
    drain("div10_latched", 1'b0);
    idle_check("div10_after");
    send(8'h96, 16'd1, 2'b10, 1'b0, 1'b0, 1'b1);
    drain("div1_is_2", 1'b0);
    idle_check("div1_after");
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_back_to_back();
    send(8'h3C, 16'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    i_TX_Byte     = 8'hC3;
    i_Parity_Mode = 2'b01;
    drain("busy_ignore", 1'b1);
    idle_check("busy_gap");
    push_frame(8'hC3, CPB, 2'b01, 1'b0);
    @(posedge CLK);
    #1;
    i_TX_DV = 1'b0;
    drain("held_dv_frame", 1'b0);
    idle_check("held_dv_after");
  endtask
`endif

  task automatic test_reset_mid();
    send(8'h00, 16'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge CLK);
    n_checks++;
    if (TX !== 1'b0 || o_TX_Active !== 1'b1) $display("FAIL mid_bit3: got tx=%b act=%b expected 0 1", TX, o_TX_Active);
    else n_pass++;
    #1;
    i_Rst_L = 1'b0;
    #1;
    n_checks++;
    if (TX !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Ready !== 1'b1 || o_TX_Done !== 1'b0)
      $display("FAIL async_abort: got tx=%b act=%b rdy=%b done=%b expected 1 0 1 0", TX, o_TX_Active, o_TX_Ready, o_TX_Done);
    else n_pass++;
    repeat (3) @(negedge CLK);
    i_Rst_L = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge CLK);
      n_checks++;
      if (o_TX_Done !== 1'b0 || TX !== 1'b1) $display("FAIL frame_lost cyc %0d: got done=%b tx=%b expected 0 1", c, o_TX_Done, TX);
      else n_pass++;
    end
    idle_check("abort_after");
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_burst();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(negedge CLK);
    i_Clks_Per_Bit = 16'd0;
    i_Parity_Mode  = 2'b00;
    i_Two_Stop     = 1'b0;
    for (int i = 0; i < 4; i++) push_frame(vals[i], CPB, 2'b00, 1'b0);
    n_checks++;
    if (o_TX_Ready !== 1'b1) $display("FAIL fifo_ready0: got %b expected 1", o_TX_Ready);
    else n_pass++;
    i_TX_Byte = vals[0];
    i_TX_DV   = 1'b1;
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          @(negedge CLK);
          n_checks++;
          if (o_TX_Ready !== ((i < 4) ? 1'b1 : 1'b0))
            $display("FAIL fifo_ready%0d: got %b expected %b", i, o_TX_Ready, (i < 4) ? 1'b1 : 1'b0);
          else n_pass++;
          i_TX_Byte = vals[i];
        end
        @(negedge CLK);
        i_TX_DV = 1'b0;
      end
      drain("fifo_burst", 1'b0);
    join
    idle_check("fifo_after");
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_divisor();
`ifndef UART_TX_FIFO_EN
    test_back_to_back();
`endif
    test_reset_mid();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
`default_nettype wire
